// File: rtl/gf2m_pkg.sv
// Shared constants and types for the GF(2^M) inverter (B-283 / K-283 field).
package gf2m_pkg;

    localparam int GF_M = 283;

    // x^283 + x^12 + x^7 + x^5 + 1
    localparam logic [GF_M:0] GF_POLY = (284'd1 << 283) | 284'h1000 | 284'h80 | 284'h20 | 284'h1;

    localparam int GF_ITER_W  = $clog2(2 * GF_M);
    localparam int GF_DELTA_W = GF_ITER_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/gf2m_xmod_step.sv
// Single-step polynomial scaling modulo f: x*u mod f, or u/x mod f when div is set.
module gf2m_xmod_step
    import gf2m_pkg::*;
#(
    parameter int            M    = GF_M,
    parameter logic [M:0]    POLY = GF_POLY
) (
    input  logic [M-1:0] u,
    input  logic         div,
    output logic [M-1:0] res
);

    logic [M-1:0] odd_fix;

    // Multiply folds the carried-out x^M back in; divide makes u even first by adding f.
    always_comb begin
        odd_fix = u[0] ? (u ^ POLY[M-1:0]) : u;
        if (div) begin
            res = (odd_fix >> 1) | {u[0] & POLY[0], {(M-1){1'b0}}};
        end else begin
            res = (u << 1) ^ (u[M-1] ? POLY[M-1:0] : {M{1'b0}});
        end
    end

endmodule

// File: rtl/gf2m_inverter.sv
// Constant-latency GF(2^M) inverter: Brunner binary-Euclid, 2M iterations per operand.
// The inverse ends up in U after the final iteration (V holds the cofactor side).
module gf2m_inverter
    import gf2m_pkg::*;
#(
    parameter int         M    = GF_M,
    parameter logic [M:0] POLY = GF_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] y,
    output logic         zero_err
);

    localparam int ITER_W  = $clog2(2 * M);
    localparam int DELTA_W = ITER_W + 1;

    state_t state, state_nx;

    logic [M:0]                r, s, r_nx, s_nx, s_x;
    logic [M-1:0]              u, v, u_nx, v_nx, v_x;
    logic [M-1:0]              step_in, step_out;
    logic                      step_div;
    logic signed [DELTA_W-1:0] delta, delta_nx;
    logic [ITER_W-1:0]         iter;
    logic                      zero_flag;
    logic                      accept, last_iter;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_iter = (state == RUN) && (iter == ITER_W'(2 * M - 1));

    // One shared scaling step; the mux picks which operand is scaled and in which direction.
    gf2m_xmod_step #(
        .M    (M),
        .POLY (POLY)
    ) u_step (
        .u   (step_in),
        .div (step_div),
        .res (step_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: accept in IDLE, fixed 2M cycles in RUN, hold DONE until taken.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // One Euclid iteration: shift R while its top bit is clear, otherwise reduce S and maybe swap.
    always_comb begin
        s_x      = s[M] ? (s ^ r) : s;
        v_x      = s[M] ? (v ^ u) : v;
        r_nx     = r;
        s_nx     = s;
        v_nx     = v;
        step_in  = u;
        step_div = 1'b0;
        delta_nx = delta;
        if (!r[M]) begin
            r_nx     = r << 1;
            delta_nx = delta + DELTA_W'(1);
        end else if (delta == '0) begin
            r_nx     = s_x << 1;
            s_nx     = r;
            step_in  = v_x;
            v_nx     = u;
            delta_nx = DELTA_W'(1);
        end else begin
            s_nx     = s_x << 1;
            v_nx     = v_x;
            step_div = 1'b1;
            delta_nx = delta - DELTA_W'(1);
        end
        u_nx = step_out;
    end

    // Datapath and output registers; the result is captured on the edge that finishes RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r         <= '0;
            s         <= '0;
            u         <= '0;
            v         <= '0;
            delta     <= '0;
            iter      <= '0;
            zero_flag <= 1'b0;
            y         <= '0;
            zero_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        r         <= {1'b0, a};
                        s         <= POLY;
                        u         <= {{(M-1){1'b0}}, 1'b1};
                        v         <= '0;
                        delta     <= '0;
                        iter      <= '0;
                        zero_flag <= (a == '0);
                    end
                end
                RUN: begin
                    r     <= r_nx;
                    s     <= s_nx;
                    u     <= u_nx;
                    v     <= v_nx;
                    delta <= delta_nx;
                    iter  <= iter + ITER_W'(1);
                    if (last_iter) begin
                        y        <= zero_flag ? '0 : u_nx;
                        zero_err <= zero_flag;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        y        <= '0;
                        zero_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
